// File: rtl/rc4_stream_xor.sv
// Buffers RC4 keystream bytes in a small FIFO and XORs them, one per byte,
// into a valid/ready byte stream with frame tracking and overflow detection.
module rc4_stream_xor #(
  parameter int KS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_done,
  input  logic [7:0]  ks_byte,
  input  logic        ks_ready,
  output logic        ks_req,
  input  logic [7:0]  data_in,
  input  logic        data_in_valid,
  input  logic        data_in_last,
  output logic        data_in_ready,
  output logic [7:0]  data_out,
  output logic        data_out_valid,
  output logic        data_out_last,
  input  logic        data_out_ready,
  output logic [15:0] byte_count,
  output logic        ks_overflow
);

  localparam int AW = $clog2(KS_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {WAIT_INIT = 1'b0, RUN = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [7:0]     ks_mem_q [KS_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [7:0]     data_out_q, data_out_d;
  logic           data_out_valid_q, data_out_valid_d;
  logic           data_out_last_q, data_out_last_d;
  logic [15:0]    byte_count_q, byte_count_d;
  logic           ks_overflow_q, ks_overflow_d;

  logic           in_run, fifo_empty, fifo_full, flush;
  logic           in_hs, out_hs, push_req, push_ok;
  logic [7:0]     fifo_head;

  always_comb begin
    in_run     = (state_q == RUN);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(KS_DEPTH));
    fifo_head  = ks_mem_q[rd_ptr_q];
    flush      = in_run && !init_done;

    // Two free slots leave room for one byte still in flight after ks_req drops.
    ks_req        = in_run && (count_q <= CW'(KS_DEPTH - 2));
    data_in_ready = in_run && !fifo_empty && (!data_out_valid_q || data_out_ready);

    in_hs    = data_in_valid && data_in_ready;
    out_hs   = data_out_valid_q && data_out_ready;
    push_req = in_run && ks_ready;
    push_ok  = push_req && (!fifo_full || in_hs);

    state_d = state_q;
    if (!in_run && init_done) begin
      state_d = RUN;
    end else if (flush) begin
      state_d = WAIT_INIT;
    end

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (in_hs)   rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + {{(CW-1){1'b0}}, push_ok} - {{(CW-1){1'b0}}, in_hs};
    end

    ks_overflow_d = ks_overflow_q || (push_req && fifo_full && !in_hs);

    data_out_d       = data_out_q;
    data_out_last_d  = data_out_last_q;
    data_out_valid_d = data_out_valid_q;
    if (in_hs) begin
      data_out_d       = data_in ^ fifo_head;
      data_out_last_d  = data_in_last;
      data_out_valid_d = 1'b1;
    end else if (out_hs) begin
      data_out_valid_d = 1'b0;
    end

    byte_count_d = byte_count_q;
    if (out_hs) begin
      byte_count_d = data_out_last_q ? 16'd0 : byte_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= WAIT_INIT;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
      data_out_last_q  <= 1'b0;
      byte_count_q     <= '0;
      ks_overflow_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      data_out_q       <= data_out_d;
      data_out_valid_q <= data_out_valid_d;
      data_out_last_q  <= data_out_last_d;
      byte_count_q     <= byte_count_d;
      ks_overflow_q    <= ks_overflow_d;
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push_ok && !flush) begin
      ks_mem_q[wr_ptr_q] <= ks_byte;
    end
  end

  assign data_out       = data_out_q;
  assign data_out_valid = data_out_valid_q;
  assign data_out_last  = data_out_last_q;
  assign byte_count     = byte_count_q;
  assign ks_overflow    = ks_overflow_q;

endmodule

// File: tb/tb_rc4_stream_xor.sv
// Directed bench for rc4_stream_xor: fill, XOR, backpressure, framing, rekey,
// overflow and reset, each scenario checking its own hand-computed values.
module tb_rc4_stream_xor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_done = 1'b0;
  logic [7:0]  ks_byte = 8'h00;
  logic        ks_ready = 1'b0;
  logic        ks_req;
  logic [7:0]  data_in = 8'h00;
  logic        data_in_valid = 1'b0;
  logic        data_in_last = 1'b0;
  logic        data_in_ready;
  logic [7:0]  data_out;
  logic        data_out_valid;
  logic        data_out_last;
  logic        data_out_ready = 1'b0;
  logic [15:0] byte_count;
  logic        ks_overflow;

  int checks = 0;
  int failures = 0;

  rc4_stream_xor #(.KS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .ks_byte(ks_byte), .ks_ready(ks_ready), .ks_req(ks_req),
    .data_in(data_in), .data_in_valid(data_in_valid), .data_in_last(data_in_last),
    .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_last(data_out_last),
    .data_out_ready(data_out_ready),
    .byte_count(byte_count), .ks_overflow(ks_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (ks_req !== 1'b0) begin failures++; $display("FAIL reset_ks_req got=%b exp=0", ks_req); end
    checks++; if (data_in_ready !== 1'b0) begin failures++; $display("FAIL reset_din_ready got=%b exp=0", data_in_ready); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_dout got=%h exp=00", data_out); end
    checks++; if (data_out_valid !== 1'b0) begin failures++; $display("FAIL reset_dout_valid got=%b exp=0", data_out_valid); end
    checks++; if (data_out_last !== 1'b0) begin failures++; $display("FAIL reset_dout_last got=%b exp=0", data_out_last); end
    checks++; if (byte_count !== 16'd0) begin failures++; $display("FAIL reset_byte_count got=%0d exp=0", byte_count); end
    checks++; if (ks_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", ks_overflow); end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_fill();
    logic [7:0] fill_bytes [4];
    logic       exp_req [4];
    fill_bytes = '{8'hA5, 8'h3C, 8'h11, 8'h22};
    exp_req    = '{1'b1, 1'b1, 1'b0, 1'b0};
    init_done = 1'b1;
    tick();
    checks++; if (ks_req !== 1'b1) begin failures++; $display("FAIL fill_req_start got=%b exp=1", ks_req); end
    for (int i = 0; i < 4; i++) begin
      ks_ready = 1'b1;
      ks_byte  = fill_bytes[i];
      tick();
      ks_ready = 1'b0;
      checks++;
      if (ks_req !== exp_req[i]) begin
        failures++; $display("FAIL fill_req_%0d got=%b exp=%b", i, ks_req, exp_req[i]);
      end
      tick();
    end
    checks++; if (ks_overflow !== 1'b0) begin failures++; $display("FAIL fill_overflow got=%b exp=0", ks_overflow); end
    checks++; if (data_in_ready !== 1'b1) begin failures++; $display("FAIL fill_din_ready got=%b exp=1", data_in_ready); end
    $display("test_fill done");
  endtask

  task automatic test_xor();
    data_out_ready = 1'b1;
    data_in = 8'hFF; data_in_valid = 1'b1; data_in_last = 1'b0;
    #1;
    checks++; if (data_in_ready !== 1'b1) begin failures++; $display("FAIL xor_din_ready got=%b exp=1", data_in_ready); end
    tick();
    checks++; if (data_out !== 8'h5A || data_out_valid !== 1'b1) begin
      failures++; $display("FAIL xor_first got=%h/%b exp=5a/1", data_out, data_out_valid); end
    data_in = 8'h00;
    tick();
    checks++; if (data_out !== 8'h3C || data_out_valid !== 1'b1) begin
      failures++; $display("FAIL xor_second got=%h/%b exp=3c/1", data_out, data_out_valid); end
    data_in_valid = 1'b0;
    tick();
    checks++; if (data_out_valid !== 1'b0) begin failures++; $display("FAIL xor_valid_clear got=%b exp=0", data_out_valid); end
    $display("test_xor done");
  endtask

  task automatic test_backpressure();
    data_out_ready = 1'b0;
    data_in = 8'h03; data_in_valid = 1'b1;
    tick();
    data_in = 8'h55;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (data_out !== 8'h12 || data_out_valid !== 1'b1 || data_in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_%0d got=%h/%b/%b exp=12/1/0", i, data_out, data_out_valid, data_in_ready);
      end
      tick();
    end
    data_out_ready = 1'b1;
    data_in = 8'h22;
    tick();
    checks++; if (data_out !== 8'h00 || data_out_valid !== 1'b1) begin
      failures++; $display("FAIL bp_no_pop got=%h/%b exp=00/1", data_out, data_out_valid); end
    data_in_valid = 1'b0;
    tick();
    checks++; if (byte_count !== 16'd4) begin failures++; $display("FAIL bp_byte_count got=%0d exp=4", byte_count); end
    checks++; if (data_in_ready !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", data_in_ready); end
    $display("test_backpressure done");
  endtask

  task automatic test_framing();
    logic [7:0]  din [3];
    logic [7:0]  exp_out [3];
    logic [15:0] exp_cnt [4];
    din     = '{8'h10, 8'h20, 8'h30};
    exp_out = '{8'h11, 8'h22, 8'h33};
    exp_cnt = '{16'd0, 16'd1, 16'd2, 16'd0};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      ks_ready = 1'b1; ks_byte = 8'(i + 1);
      tick();
    end
    ks_ready = 1'b0;
    data_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = din[i]; data_in_valid = 1'b1; data_in_last = (i == 2);
      tick();
      checks++;
      if (data_out !== exp_out[i] || byte_count !== exp_cnt[i] || data_out_last !== (i == 2)) begin
        failures++;
        $display("FAIL frame_%0d got=%h cnt=%0d last=%b exp=%h cnt=%0d", i, data_out, byte_count,
                 data_out_last, exp_out[i], exp_cnt[i]);
      end
    end
    data_in_valid = 1'b0; data_in_last = 1'b0;
    tick();
    checks++; if (byte_count !== exp_cnt[3]) begin failures++; $display("FAIL frame_end_count got=%0d exp=0", byte_count); end
    $display("test_framing done");
  endtask

  task automatic test_rekey();
    ks_ready = 1'b1; ks_byte = 8'h44; tick();
    ks_byte = 8'h55; tick();
    ks_ready = 1'b0; init_done = 1'b0;
    tick();
    checks++; if (ks_req !== 1'b0 || data_in_ready !== 1'b0) begin
      failures++; $display("FAIL rekey_wait got=%b/%b exp=0/0", ks_req, data_in_ready); end
    ks_ready = 1'b1; ks_byte = 8'h99; init_done = 1'b1;
    tick();
    ks_ready = 1'b0;
    checks++; if (ks_req !== 1'b1 || data_in_ready !== 1'b0) begin
      failures++; $display("FAIL rekey_flushed got=%b/%b exp=1/0", ks_req, data_in_ready); end
    ks_ready = 1'b1; ks_byte = 8'h66; tick();
    ks_ready = 1'b0;
    data_in = 8'h00; data_in_valid = 1'b1; data_out_ready = 1'b1;
    tick();
    checks++; if (data_out !== 8'h66) begin failures++; $display("FAIL rekey_first got=%h exp=66", data_out); end
    data_in_valid = 1'b0;
    tick();
    $display("test_rekey done");
  endtask

  task automatic test_overflow_reset();
    logic [7:0] exp_drain [4];
    exp_drain = '{8'h71, 8'h72, 8'h73, 8'h80};
    for (int i = 0; i < 4; i++) begin
      ks_ready = 1'b1; ks_byte = 8'(8'h70 + i);
      tick();
    end
    checks++; if (ks_overflow !== 1'b0) begin failures++; $display("FAIL ovf_full_nonerr got=%b exp=0", ks_overflow); end
    ks_byte = 8'h74;
    tick();
    ks_ready = 1'b0;
    checks++; if (ks_overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", ks_overflow); end
    tick();
    checks++; if (ks_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", ks_overflow); end
    // Push and pop together while full: head leaves, new byte joins the tail.
    ks_ready = 1'b1; ks_byte = 8'h80;
    data_in = 8'h00; data_in_valid = 1'b1;
    tick();
    ks_ready = 1'b0;
    checks++; if (data_out !== 8'h70) begin failures++; $display("FAIL ovf_full_pushpop got=%h exp=70", data_out); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (data_out !== exp_drain[i]) begin
        failures++; $display("FAIL ovf_drain_%0d got=%h exp=%h", i, data_out, exp_drain[i]);
      end
    end
    data_in_valid = 1'b0;
    #1;
    checks++; if (data_in_ready !== 1'b0) begin failures++; $display("FAIL ovf_drained got=%b exp=0", data_in_ready); end
    rst = 1'b1;
    tick();
    checks++;
    if (ks_req !== 1'b0 || data_in_ready !== 1'b0 || data_out !== 8'h00 || data_out_valid !== 1'b0 ||
        data_out_last !== 1'b0 || byte_count !== 16'd0 || ks_overflow !== 1'b0) begin
      failures++;
      $display("FAIL final_reset got req=%b rdy=%b dout=%h v=%b l=%b cnt=%0d ovf=%b exp all 0",
               ks_req, data_in_ready, data_out, data_out_valid, data_out_last, byte_count, ks_overflow);
    end
    rst = 1'b0;
    $display("test_overflow_reset done");
  endtask

  initial begin
    test_reset();
    test_fill();
    test_xor();
    test_backpressure();
    test_framing();
    test_rekey();
    test_overflow_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
